// File: rtl/pipe_stage_skid_reg.sv
// Parametrised pipeline stage register with a valid/ready handshake, a 2-entry skid buffer and flush.
// Define PIPE_STAGE_PERF_EN to add the stall_cnt and squash_cnt performance counters.
module pipe_stage_skid_reg #(
    parameter int                 CTRL_W      = 16,
    parameter int                 DATA_W      = 96,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       squash_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stateT;

    stateT             stateReg;
    logic              outValidReg;
    logic              inReadyReg;
    logic [CTRL_W-1:0] mainCtrlReg;
    logic [DATA_W-1:0] mainDataReg;
    logic [CTRL_W-1:0] skidCtrlReg;
    logic [DATA_W-1:0] skidDataReg;

    logic accept;
    logic retire;

    assign accept = in_valid & inReadyReg;
    assign retire = outValidReg & out_ready;

    assign in_ready  = inReadyReg;
    assign out_valid = outValidReg;
    assign out_ctrl  = mainCtrlReg;
    assign out_data  = mainDataReg;

    // mainCtrlReg is loaded with CTRL_BUBBLE on every path that empties the stage,
    // so out_ctrl needs no output mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= EMPTY;
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
            mainCtrlReg <= CTRL_BUBBLE;
            mainDataReg <= '0;
            skidCtrlReg <= CTRL_BUBBLE;
            skidDataReg <= '0;
        end else if (flush) begin
            // Everything held or arriving this cycle is younger than the branch.
            stateReg    <= EMPTY;
            outValidReg <= 1'b0;
            inReadyReg  <= 1'b1;
            mainCtrlReg <= CTRL_BUBBLE;
        end else begin
            case (stateReg)
                EMPTY: begin
                    if (accept) begin
                        stateReg    <= ONE;
                        outValidReg <= 1'b1;
                        mainCtrlReg <= in_ctrl;
                        mainDataReg <= in_data;
                    end
                end
                ONE: begin
                    if (accept && retire) begin
                        mainCtrlReg <= in_ctrl;
                        mainDataReg <= in_data;
                    end else if (accept) begin
                        stateReg    <= TWO;
                        inReadyReg  <= 1'b0;
                        skidCtrlReg <= in_ctrl;
                        skidDataReg <= in_data;
                    end else if (retire) begin
                        stateReg    <= EMPTY;
                        outValidReg <= 1'b0;
                        mainCtrlReg <= CTRL_BUBBLE;
                    end
                end
                TWO: begin
                    if (retire) begin
                        stateReg    <= ONE;
                        inReadyReg  <= 1'b1;
                        mainCtrlReg <= skidCtrlReg;
                        mainDataReg <= skidDataReg;
                    end
                end
                default: begin
                    stateReg    <= EMPTY;
                    outValidReg <= 1'b0;
                    inReadyReg  <= 1'b1;
                    mainCtrlReg <= CTRL_BUBBLE;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stallCntReg;
    logic [31:0] squashCntReg;

    assign stall_cnt  = stallCntReg;
    assign squash_cnt = squashCntReg;

    // Counters run through flush; a squash is counted only if something was actually discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCntReg  <= '0;
            squashCntReg <= '0;
        end else begin
            if (outValidReg && !out_ready) begin
                stallCntReg <= stallCntReg + 32'd1;
            end
            if (flush && ((stateReg != EMPTY) || accept)) begin
                squashCntReg <= squashCntReg + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_skid_reg;

    localparam int CTRL_W = 16;
    localparam int DATA_W = 96;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } entT;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       squash_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W),
        .CTRL_BUBBLE(16'h0000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_data (out_data)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .squash_cnt(squash_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: an ordered queue of at most two entries.
    entT               mq[$];
    logic [DATA_W-1:0] lastData = '0;
    int unsigned       stallM   = 0;
    int unsigned       squashM  = 0;

    task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [CTRL_W-1:0] ic, input logic [DATA_W-1:0] id,
                        input logic ordy);
        logic acc;
        logic ret;
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        acc = iv && (mq.size() < 2);
        ret = ordy && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            lastData = '0;
            stallM   = 0;
            squashM  = 0;
        end else begin
            if (mq.size() > 0 && !ordy) stallM++;
            if (fl && (mq.size() > 0 || acc)) squashM++;
            if (fl) begin
                mq.delete();
            end else begin
                if (ret) begin
                    $display("retire ctrl=%04h data=%024h", mq[0].c, mq[0].d);
                    mq.delete(0);
                end
                if (acc) mq.push_back('{c: ic, d: id});
            end
        end
        if (mq.size() > 0) lastData = mq[0].d;
        checkVal("out_valid", 128'(out_valid), 128'(mq.size() > 0));
        checkVal("out_ctrl",  128'(out_ctrl),  128'((mq.size() > 0) ? mq[0].c : 16'h0000));
        checkVal("out_data",  128'(out_data),  128'((mq.size() > 0) ? mq[0].d : lastData));
        checkVal("in_ready",  128'(in_ready),  128'(mq.size() < 2));
`ifdef PIPE_STAGE_PERF_EN
        checkVal("stall_cnt",  128'(stall_cnt),  128'(stallM));
        checkVal("squash_cnt", 128'(squash_cnt), 128'(squashM));
`endif
    endtask

    function automatic logic [DATA_W-1:0] rndData();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        // Reset with a valid input held: nothing may be captured.
        step(1, 0, 1, 16'hABCD, rndData(), 1);
        step(1, 0, 1, 16'hABCD, rndData(), 1);
        step(0, 0, 0, 16'h0000, '0, 1);

        // Full-throughput stream.
        for (int i = 1; i <= 4; i++) step(0, 0, 1, CTRL_W'(i), rndData(), 1);
        step(0, 0, 0, 16'h0000, '0, 1);

        // Back-to-back 5, 6 into a stalled stage, release after 3 cycles.
        step(0, 0, 1, 16'd5, rndData(), 0);
        step(0, 0, 1, 16'd6, rndData(), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 16'h00EE, rndData(), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0000, '0, 1);

        // State TWO (7, 8) then flush with 9 arriving.
        step(0, 0, 1, 16'd7, rndData(), 0);
        step(0, 0, 1, 16'd8, rndData(), 0);
        step(0, 1, 1, 16'd9, rndData(), 1);
        step(0, 0, 0, 16'h0000, '0, 1);

        // Reset and flush together while one entry is held.
        step(0, 0, 1, 16'd10, rndData(), 0);
        step(1, 1, 1, 16'd11, rndData(), 1);
        step(0, 0, 0, 16'h0000, '0, 1);

        // Ten stall cycles, then two flushes of a valid stage.
        step(0, 0, 1, 16'd12, rndData(), 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0000, '0, 0);
        step(0, 1, 0, 16'h0000, '0, 0);
        step(0, 0, 1, 16'd13, rndData(), 0);
        step(0, 1, 0, 16'h0000, '0, 0);
        step(0, 0, 0, 16'h0000, '0, 1);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 CTRL_W'($urandom),
                 rndData(),
                 ($urandom_range(0, 9) < 6));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
